// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiplier datapath.
// Used by the dot-product sequencer and any MAC users.
package matmul_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ACCUM_W_DEF = 2 * DATA_W_DEF;
  localparam int LEN_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    FLUSH,
    CAPTURE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/dot_product_sequencer.sv
// Streams K operand pairs into a MAC, flushes it, captures the total.
// Ports: cmd (len in), op (a/b in), mac (ctrl out, total in), res (out).
module dot_product_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int ACCUM_WIDTH = 2 * DATA_WIDTH,
  parameter int LEN_WIDTH   = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [DATA_WIDTH-1:0]  op_a,
  input  logic [DATA_WIDTH-1:0]  op_b,
  output logic                   mac_clr,
  output logic                   mac_run,
  output logic [DATA_WIDTH-1:0]  mac_in1,
  output logic [DATA_WIDTH-1:0]  mac_in2,
  input  logic [ACCUM_WIDTH-1:0] mac_total,
  input  logic                   mac_err,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACCUM_WIDTH-1:0] res_total,
  output logic                   res_err
);

  localparam logic [LEN_WIDTH-1:0] ONE = 1;

  seq_state_t state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACCUM_WIDTH-1:0] res_total_q, res_total_d;
  logic                   res_err_q, res_err_d;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    res_total_d = res_total_q;
    res_err_d   = res_err_q;
    cmd_ready   = 1'b0;
    op_ready    = 1'b0;
    mac_clr     = 1'b0;
    mac_run     = 1'b0;
    mac_in1     = '0;
    mac_in2     = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        mac_clr   = 1'b1;
        if (cmd_valid) begin
          len_d   = cmd_len;
          cnt_d   = '0;
          state_d = (cmd_len != '0) ? STREAM : FLUSH;
        end
      end
      STREAM: begin
        op_ready = 1'b1;
        if (op_valid) begin
          mac_run = 1'b1;
          mac_in1 = op_a;
          mac_in2 = op_b;
          cnt_d   = cnt_q + ONE;
          if (cnt_q == len_q - ONE) begin
            state_d = FLUSH;
          end
        end
      end
      // one extra run pushes the last product into the total
      FLUSH: begin
        mac_run = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        res_total_d = mac_total;
        res_err_d   = mac_err;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // reset clears the MAC even if a job was mid-stream
    if (rst) begin
      cmd_ready = 1'b0;
      op_ready  = 1'b0;
      mac_clr   = 1'b1;
      mac_run   = 1'b0;
      mac_in1   = '0;
      mac_in2   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      res_total_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      res_total_q <= res_total_d;
      res_err_q   <= res_err_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_total = res_total_q;
  assign res_err   = res_err_q;

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Sequencer that sits directly upstream of the MAC in the matrix-multiplier datapath. It accepts one dot-product job (a length K), streams K operand pairs into the MAC with the correct clr/run sequencing, and flushes the MAC's product register. It then captures the accumulated total and overflow flag and presents them on a valid/ready result port.

## Interface
- DATA_WIDTH, 16, operand width (signed)
- ACCUM_WIDTH, 2*DATA_WIDTH, MAC accumulator width; must be ≥ 2*DATA_WIDTH
- LEN_WIDTH, 8, width of job length K
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted when valid & ready
- cmd_len  in  LEN_WIDTH  K, operand pairs in job (0 legal)
- op_valid  in  1  operand pair available
- op_ready  out  1  operand pair consumed when valid & ready
- op_a, op_b  in  DATA_WIDTH  signed operands
- mac_clr  out  1  to MAC clr
- mac_run  out  1  to MAC run
- mac_in1, mac_in2  out  DATA_WIDTH  to MAC in1/in2
- mac_total  in  ACCUM_WIDTH  from MAC total
- mac_err  in  1  from MAC err
- res_valid  out  1  result available
- res_ready  in  1  result consumed when valid & ready
- res_total  out  ACCUM_WIDTH  captured dot product (signed)
- res_err  out  1  captured overflow flag

## Operation
- MAC model: on run, product_reg <= in1*in2 and total <= total + old product_reg; clr zeroes both and err. The last product therefore needs one extra run cycle (flush).
- States: IDLE, STREAM, FLUSH, CAPTURE, DONE.
- IDLE: cmd_ready=1, mac_clr=1, mac_run=0. On cmd handshake, latch cmd_len and zero the counter. Go to STREAM if len≠0, else FLUSH.
- STREAM: op_ready=1. mac_run = op_valid. mac_in1/in2 = op_a/op_b on transfer, else 0. A stall (op_valid=0) leaves the MAC frozen. Each transfer increments the counter. The transfer with count==len-1 moves to FLUSH.
- FLUSH: mac_run=1, mac_in1=mac_in2=0 for one cycle; then CAPTURE.
- CAPTURE: res_total <= mac_total, res_err <= mac_err; then DONE.
- DONE: res_valid=1, registered outputs held stable. On res_ready, go to IDLE. The MAC is cleared in IDLE, never while a result is pending.
- Outside the stated cases: mac_clr=0, mac_run=0, mac_in1/in2=0, op_ready=0, cmd_ready=0.
- Arithmetic is done entirely by the MAC. The block passes total/err through unmodified. Overflow is sticky per job, reported via res_err, and does not abort the job.
- Only one job is in flight. cmd is not accepted until the result has been consumed.

## Timing
- Reset values: state IDLE, counter 0, res_valid 0, res_total 0, res_err 0, op_ready 0. cmd_ready is 1 from the first cycle after reset.
- While rst=1: mac_clr=1 and mac_run=0, overriding state decode. This ensures the MAC is cleared on reset mid-job. Partial operands are dropped, and no result is produced for an interrupted job.
- Latency with op_valid held high: cmd handshake in cycle 0 → STREAM cycles 1..K, FLUSH K+1, CAPTURE K+2, res_valid=1 in cycle K+3. K=0 gives res_valid in cycle 3 with total 0.
- Each op_valid gap of N cycles adds N cycles of latency.
- res_valid held with res_ready=0: outputs stable indefinitely.
- res handshake in cycle R: cmd_ready=1 in cycle R+1.
- A cmd_valid asserted while not IDLE is ignored (not accepted).
- cmd_len=2^LEN_WIDTH-1 is legal; the counter is LEN_WIDTH bits and never wraps within a job.

## Structure
- Shared package matmul_pkg: seq_state_t enum (IDLE, STREAM, FLUSH, CAPTURE, DONE) and default width constants shared with MAC users.
- No sub-module. The counter and FSM are inline. The MAC is instantiated by the parent, not inside this block.

## Test plan
- K=3, a={2,-3,4}, b={5,6,-1}, op_valid and res_ready high → res_total=-12, res_err=0, res_valid first in cycle 6 after cmd.
- K=0 → res_total=0, res_err=0, res_valid in cycle 3, op_ready never asserted.
- K=4 with op_valid low for 2 cycles between each pair, a=b=100 → res_total=40000, res_valid in cycle 7+6=13.
- DATA_WIDTH=16, ACCUM_WIDTH=32, K=3, a=b=-32768 (product 2^30) → res_err=1; the next job K=1 (3×4) → res_total=12, res_err=0 (clr between jobs).
- Hold res_ready=0 for 10 cycles → res_total/res_err stable, cmd_ready=0 throughout; cmd_ready rises the cycle after the handshake.
- Assert rst in the middle of STREAM → next cycle state IDLE, res_valid=0, mac_clr=1 during reset; a following job K=2 (1×1, 2×2) → res_total=5.
